osc_state_driver: RTL and testbench

//  Stimulus side of the 4-state oscillating Mealy FSM (state bits b1b0; A=0 toggles b0, A=1 toggles b1, y=A).

---
 rtl/osc_state_driver.sv | 97 +++++++++
 tb/tb_osc_state_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/osc_state_driver.sv
// Steers a 4-state oscillating Mealy FSM (A=0 toggles b0, A=1 toggles b1, y=A)
// to a requested state in the fewest clocks, mirroring its state and checking y.
module osc_state_driver #(
  parameter logic IDLE_A    = 1'b0,
  parameter int   ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [1:0]           req_target,
  output logic                 req_ready,
  output logic                 a_out,
  input  logic                 y_in,
  output logic [1:0]           cur_state,
  output logic                 done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic {
    IDLE,
    DRIVE
  } state_t;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [1:0] tgt;
  logic [1:0] m_next;
  logic [1:0] d_req;
  logic [1:0] d_tgt;

  // The FSM never holds: whatever A we drive this cycle moves the mirror on the edge.
  assign m_next    = cur_state ^ (a_out ? 2'b10 : 2'b01);
  assign d_req     = m_next ^ req_target;
  assign d_tgt     = m_next ^ tgt;
  assign req_ready = (state == IDLE);

  // Fix b0 first (A=0), then b1 (A=1); at most two steering cycles.
  function automatic logic steer(input logic [1:0] d);
    return d[0] ? 1'b0 : 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tgt       <= 2'b00;
      cur_state <= 2'b00;
      a_out     <= IDLE_A;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      cur_state <= m_next;

      if (y_in != a_out) begin
        err <= 1'b1;
        if (err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + CNT_ONE;
        end
      end

      case (state)
        IDLE: begin
          done  <= 1'b0;
          a_out <= IDLE_A;
          if (req_valid) begin
            tgt <= req_target;
            if (d_req == 2'b00) begin
              done <= 1'b1;
            end else begin
              state <= DRIVE;
              a_out <= steer(d_req);
            end
          end
        end
        DRIVE: begin
          if (d_tgt == 2'b00) begin
            done  <= 1'b1;
            a_out <= IDLE_A;
            state <= IDLE;
          end else begin
            done  <= 1'b0;
            a_out <= steer(d_tgt);
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          a_out <= IDLE_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osc_state_driver.sv
// Directed plus randomized checks of osc_state_driver against a plan-based
// reference model of the steering, mirror and mismatch checker.
module tb_osc_state_driver;

  localparam logic IDLE_A    = 1'b0;
  localparam int   ERR_CNT_W = 8;
  localparam int   CNT_MAX   = (1 << ERR_CNT_W) - 1;

  logic                 clk;
  logic                 rst;
  logic                 req_valid;
  logic [1:0]           req_target;
  logic                 req_ready;
  logic                 a_out;
  logic                 y_in;
  logic [1:0]           cur_state;
  logic                 done;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;

  osc_state_driver #(
    .IDLE_A   (IDLE_A),
    .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_target(req_target),
    .req_ready (req_ready),
    .a_out     (a_out),
    .y_in      (y_in),
    .cur_state (cur_state),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a request becomes a queue of A values that flip the
  // differing bits (b0 first), after which done follows one edge later.
  logic [1:0] m_state;
  logic       m_a;
  logic       m_done;
  logic       m_busy;
  logic       m_err;
  int         m_cnt;
  logic       plan[$];

  task automatic model_step(input logic r, input logic v, input logic [1:0] t, input logic y);
    logic [1:0] nxt;
    logic [1:0] d;
    if (!r) begin
      m_state = 2'b00; m_a = IDLE_A; m_done = 1'b0; m_busy = 1'b0;
      m_err = 1'b0; m_cnt = 0; plan.delete();
      return;
    end
    nxt = m_state ^ (m_a ? 2'b10 : 2'b01);
    if (y != m_a) begin
      m_err = 1'b1;
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end
    if (!m_busy) begin
      m_done = 1'b0;
      m_a    = IDLE_A;
      if (v) begin
        d = nxt ^ t;
        if (d[0]) plan.push_back(1'b0);
        if (d[1]) plan.push_back(1'b1);
        if (plan.size() == 0) begin
          m_done = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_a    = plan.pop_front();
        end
      end
    end else if (plan.size() == 0) begin
      m_done = 1'b1;
      m_a    = IDLE_A;
      m_busy = 1'b0;
    end else begin
      m_a = plan.pop_front();
    end
    m_state = nxt;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check_val("cur_state", {30'd0, cur_state}, {30'd0, m_state});
    check_val("a_out", {31'd0, a_out}, {31'd0, m_a});
    check_val("done", {31'd0, done}, {31'd0, m_done});
    check_val("req_ready", {31'd0, req_ready}, {31'd0, ~m_busy});
    check_val("err", {31'd0, err}, {31'd0, m_err});
    check_val("err_cnt", {24'd0, err_cnt}, m_cnt);
  endtask

  // Drives one cycle's inputs at the falling edge; y_in is the model's A, optionally inverted.
  task automatic apply_stimulus(input logic r, input logic v, input logic [1:0] t, input logic flip);
    logic y;
    y          = m_a ^ flip;
    rst        = r;
    req_valid  = v;
    req_target = t;
    y_in       = y;
    @(posedge clk);
    model_step(r, v, t, y);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] t;
    rst = 1'b0; req_valid = 1'b0; req_target = 2'b00; y_in = IDLE_A;
    m_state = 2'b00; m_a = IDLE_A; m_done = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_cnt = 0;
    @(negedge clk);

    // Reset, then free oscillation 00,01,00,...
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
    check_output();
    check_val("rst_cur", {30'd0, cur_state}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0);
      check_output();
    end
    check_val("idle_cur", {30'd0, cur_state}, 32'd0);

    // m_next=01, target 11: one A=1 cycle, then done at 11
    apply_stimulus(1'b1, 1'b1, 2'b11, 1'b0);
    check_output();
    check_val("t2_a_out", {31'd0, a_out}, 32'd1);
    apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0);
    check_output();
    check_val("t2_done", {31'd0, done}, 32'd1);
    check_val("t2_cur", {30'd0, cur_state}, 32'd3);
    check_val("t2_ready", {31'd0, req_ready}, 32'd1);
    apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0);
    check_output();

    // Walk back to 00 with a request, then idle until mirror is 00 again
    apply_stimulus(1'b1, 1'b1, 2'b00, 1'b0);
    check_output();
    for (int i = 0; i < 8 && (m_state != 2'b00 || m_busy); i++) begin
      apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0);
      check_output();
    end
    check_val("t3_start", {30'd0, cur_state}, 32'd0);

    // m_next=01, target 10: A=0 then A=1, cur 01,00,10
    apply_stimulus(1'b1, 1'b1, 2'b10, 1'b0);
    check_output();
    check_val("t3_a0", {31'd0, a_out}, 32'd0);
    apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0);
    check_output();
    check_val("t3_a1", {31'd0, a_out}, 32'd1);
    check_val("t3_cur1", {30'd0, cur_state}, 32'd0);
    apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0);
    check_output();
    check_val("t3_done", {31'd0, done}, 32'd1);
    check_val("t3_cur2", {30'd0, cur_state}, 32'd2);

    // Target equal to m_next, twice back to back
    apply_stimulus(1'b1, 1'b1, 2'b11, 1'b0);
    check_output();
    check_val("t4_done", {31'd0, done}, 32'd1);
    check_val("t4_ready", {31'd0, req_ready}, 32'd1);
    apply_stimulus(1'b1, 1'b1, 2'b10, 1'b0);
    check_output();
    check_val("t4_done2", {31'd0, done}, 32'd1);
    check_val("t4_cur2", {30'd0, cur_state}, 32'd2);
    apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0);
    check_output();

    // Persistent mismatch: counter saturates and holds
    apply_stimulus(1'b1, 1'b0, 2'b00, 1'b1);
    check_output();
    check_val("t5_err", {31'd0, err}, 32'd1);
    for (int i = 1; i < 300; i++) begin
      apply_stimulus(1'b1, 1'b0, 2'b00, 1'b1);
      check_output();
    end
    check_val("t5_sat", {24'd0, err_cnt}, CNT_MAX);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0);
      check_output();
    end
    check_val("t5_hold", {24'd0, err_cnt}, CNT_MAX);

    // Reset in the middle of a two-step drive
    t = m_state ^ 2'b01 ^ 2'b11;
    apply_stimulus(1'b1, 1'b1, t, 1'b0);
    check_output();
    check_val("t6_busy", {31'd0, req_ready}, 32'd0);
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
    check_output();
    check_val("t6_cur", {30'd0, cur_state}, 32'd0);
    check_val("t6_done", {31'd0, done}, 32'd0);
    check_val("t6_ready", {31'd0, req_ready}, 32'd1);
    check_val("t6_err", {31'd0, err}, 32'd0);
    check_val("t6_cnt", {24'd0, err_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0);
      check_output();
    end

    // Randomized traffic with occasional resets and y glitches
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
                     2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
      check_output();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
